ecc_sec_encoder_pipe: RTL and testbench

- Streaming single-error-correcting (SEC) check-bit generator for 32-bit data words.
- Sits directly upstream of the 32-bit SEC corrector. Produces the 8 check bits that drive the corrector to zero syndrome for the same data word.
- Two-stage valid/ready pipeline with full backpressure and a saturating count of encoded words.

---
 rtl/ecc_sec_pkg.sv | 34 +++
 rtl/ecc_sec_chkgen.sv | 23 ++
 rtl/ecc_sec_encoder_pipe.sv | 136 +++++++++++++
 tb/tb_ecc_sec_encoder_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_sec_pkg.sv
// Shared definitions for the 32-bit SEC encoder/corrector pair: widths, coverage masks, codeword layout.
package ecc_sec_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int NIB_N  = DATA_W / 4;
    localparam int CW_W   = DATA_W + CHK_W;

    // Bit i of CHK_MASK[k] set means data bit i contributes to check bit k.
    localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
        32'h00FF_1111,
        32'hFF00_2222,
        32'h0F0F_4444,
        32'hF0F0_8888,
        32'h1111_00FF,
        32'h2222_FF00,
        32'h4444_0F0F,
        32'h8888_F0F0
    };

    typedef struct packed {
        logic [CHK_W-1:0]  chk;
        logic [DATA_W-1:0] data;
    } codeword_t;

    function automatic logic [CHK_W-1:0] ecc_chk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        for (int k = 0; k < CHK_W; k++) begin
            c[k] = ^(d & CHK_MASK[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ecc_sec_chkgen.sv
// Check-bit combiner: whole nibbles covered by a mask use precomputed nibble parities, the rest use data bits.
module ecc_sec_chkgen
    import ecc_sec_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [NIB_N-1:0]  nib_par,
    output logic [CHK_W-1:0]  chk
);

    always_comb begin
        chk = '0;
        for (int k = 0; k < CHK_W; k++) begin
            for (int n = 0; n < NIB_N; n++) begin
                if (CHK_MASK[k][4*n +: 4] == 4'hF) begin
                    chk[k] = chk[k] ^ nib_par[n];
                end else begin
                    chk[k] = chk[k] ^ (^(data[4*n +: 4] & CHK_MASK[k][4*n +: 4]));
                end
            end
        end
    end

endmodule

// File: rtl/ecc_sec_encoder_pipe.sv
// Two-stage SEC check-bit generator with valid/ready backpressure and a saturating handoff counter.
// Optional error injector enabled by defining ECC_ERR_INJECT_EN.
module ecc_sec_encoder_pipe
    import ecc_sec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_check,
    input  logic              cnt_clr,
`ifdef ECC_ERR_INJECT_EN
    input  logic              inj_arm,
    input  logic [5:0]        inj_pos,
    output logic              inj_done,
`endif
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [NIB_N-1:0]  s1_nib;
    logic [NIB_N-1:0]  nib_par;
    logic [CHK_W-1:0]  s2_chk;
    logic              s1_adv;
    logic              s2_adv;
    logic              accept;
    logic              handoff;
    codeword_t         cw_next;

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid & in_ready;
    assign handoff  = out_valid & out_ready;

    always_comb begin
        nib_par = '0;
        for (int n = 0; n < NIB_N; n++) begin
            nib_par[n] = ^in_data[4*n +: 4];
        end
    end

    ecc_sec_chkgen u_chkgen (
        .data    (s1_data),
        .nib_par (s1_nib),
        .chk     (s2_chk)
    );

`ifdef ECC_ERR_INJECT_EN
    logic              armed;
    logic [5:0]        arm_pos;
    logic              s1_inj;
    logic [5:0]        s1_pos;
    logic              s2_inj;
    logic [CW_W-1:0]   flip;

    // Flip lands on the finished codeword so the check bits describe the clean data.
    assign flip     = (s1_inj && s1_pos < 6'd40) ? (CW_W'(1) << s1_pos) : '0;
    assign cw_next  = codeword_t'({s2_chk, s1_data} ^ flip);
    assign inj_done = handoff & s2_inj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            arm_pos <= '0;
            s1_inj  <= 1'b0;
            s1_pos  <= '0;
            s2_inj  <= 1'b0;
        end else begin
            if (inj_arm) begin
                armed   <= 1'b1;
                arm_pos <= inj_pos;
            end else if (accept) begin
                armed   <= 1'b0;
            end
            if (s1_adv) begin
                s1_inj <= accept & armed;
                s1_pos <= arm_pos;
            end
            if (s2_adv) begin
                s2_inj <= s1_valid & s1_inj;
            end
        end
    end
`else
    assign cw_next = codeword_t'({s2_chk, s1_data});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_nib   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_nib  <= nib_par;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_check <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= cw_next.data;
                out_check <= cw_next.chk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (cnt_clr) begin
            word_cnt <= '0;
        end else if (handoff && word_cnt != CNT_MAX) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_sec_encoder_pipe.sv
// Self-checking bench for ecc_sec_encoder_pipe against an equation-level reference model and scoreboard.
module tb_ecc_sec_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic [15:0] word_cnt;
    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [7:0]  out_check4;
    logic [3:0]  word_cnt4;
`ifdef ECC_ERR_INJECT_EN
    logic        inj_arm = 1'b0;
    logic [5:0]  inj_pos = '0;
    logic        inj_done, inj_done4;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ecc_sec_encoder_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_check(out_check),
        .cnt_clr(cnt_clr),
`ifdef ECC_ERR_INJECT_EN
        .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_done(inj_done),
`endif
        .word_cnt(word_cnt)
    );

    ecc_sec_encoder_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_check(out_check4),
        .cnt_clr(cnt_clr),
`ifdef ECC_ERR_INJECT_EN
        .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_done(inj_done4),
`endif
        .word_cnt(word_cnt4)
    );

    function automatic logic [7:0] ref_chk(input logic [31:0] d);
        logic [7:0] c;
        c[0] = (^d[23:16]) ^ d[0] ^ d[4] ^ d[8] ^ d[12];
        c[1] = (^d[31:24]) ^ d[1] ^ d[5] ^ d[9] ^ d[13];
        c[2] = (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
        c[3] = (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
        c[4] = (^d[7:0]) ^ d[16] ^ d[20] ^ d[24] ^ d[28];
        c[5] = (^d[15:8]) ^ d[17] ^ d[21] ^ d[25] ^ d[29];
        c[6] = (^d[3:0]) ^ (^d[11:8]) ^ d[18] ^ d[22] ^ d[26] ^ d[30];
        c[7] = (^d[7:4]) ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_check !== 8'h0 || word_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b data=%h chk=%h cnt=%0d, required all zero",
                     out_valid, out_data, out_check, word_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vd[4];
        logic [7:0]  vc[4];
        vd = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
        vc = '{8'h00, 8'h51, 8'h8A, 8'h00};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vd[k]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_latency_early: out_valid=%b, required 0", k, out_valid);
            end
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_check !== vc[k] || out_data !== vd[k]) begin
                tests_failed++;
                $display("FAIL vec%0d: valid=%b data=%h chk=%h, required valid=1 data=%h chk=%h",
                         k, out_valid, out_data, out_check, vd[k], vc[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int sent = 0;
        int got = 0;
        int last_cyc = -1;
        logic [31:0] exp_d;
        @(negedge clk);
        cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10100 && got < 10000; cyc++) begin
            @(negedge clk);
            cnt_clr = 1'b0;
            in_valid = (sent < 10000);
            in_data = $urandom();
            #1;
            if (in_valid && !in_ready) begin
                tests_run++; tests_failed++;
                $display("FAIL sweep_in_ready: cycle %0d in_ready=0, required 1", cyc);
            end
            if (out_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sweep_extra: unexpected word %h, required none", out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (out_data !== exp_d || out_check !== ref_chk(exp_d)) begin
                        tests_failed++;
                        $display("FAIL sweep_word%0d: data=%h chk=%h, required data=%h chk=%h",
                                 got, out_data, out_check, exp_d, ref_chk(exp_d));
                    end
                end
                got++;
                last_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != 10000 || last_cyc != 10001) begin
            tests_failed++;
            $display("FAIL sweep_throughput: got %0d words, last at cycle %0d, required 10000 at 10001",
                     got, last_cyc);
        end
        @(negedge clk);
        tests_run++;
        if (word_cnt !== 16'd10000 || word_cnt4 !== 4'd15) begin
            tests_failed++;
            $display("FAIL sweep_count: cnt=%0d cnt4=%0d, required 10000 and 15", word_cnt, word_cnt4);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int i = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic [7:0]  prev_c = '0;
        logic [31:0] exp_d;
        logic exp_ready;
        while ((i < 300 || exp_q.size() != 0) && i < 2000) begin
            @(negedge clk);
            in_valid = (i < 300);
            in_data = $urandom();
            out_ready = ($urandom_range(0, 99) < 30);
            #1;
            if (prev_stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_check !== prev_c) begin
                    tests_failed++;
                    $display("FAIL bp_hold: valid=%b data=%h chk=%h, required 1 %h %h",
                             out_valid, out_data, out_check, prev_d, prev_c);
                end
            end
            exp_ready = !(exp_q.size() == 2 && !out_ready);
            tests_run++;
            if (in_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL bp_in_ready: got %b, required %b (held %0d)", in_ready, exp_ready, exp_q.size());
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_extra: unexpected word %h, required none", out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (out_data !== exp_d || out_check !== ref_chk(exp_d)) begin
                        tests_failed++;
                        $display("FAIL bp_word: data=%h chk=%h, required data=%h chk=%h",
                                 out_data, out_check, exp_d, ref_chk(exp_d));
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_c = out_check;
            i++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_drain: %0d words left, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_counter();
        int sent = 0;
        @(negedge clk);
        cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            cnt_clr = 1'b0;
            in_valid = (sent < 20);
            in_data = $urandom();
            #1;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (word_cnt !== 16'd20 || word_cnt4 !== 4'd15) begin
            tests_failed++;
            $display("FAIL cnt_sat: cnt=%0d cnt4=%0d, required 20 and 15", word_cnt, word_cnt4);
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = $urandom();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cnt_clr = out_valid;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL cnt_clr_setup: out_valid=%b, required 1", out_valid);
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        tests_run++;
        if (word_cnt !== 16'd0 || word_cnt4 !== 4'd0) begin
            tests_failed++;
            $display("FAIL cnt_clr_wins: cnt=%0d cnt4=%0d, required 0", word_cnt, word_cnt4);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] fresh;
        bit seen = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_0001;
        @(negedge clk);
        in_data = 32'hDEAD_0002;
        @(negedge clk);
        in_data = 32'hDEAD_0003;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_full: in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_flush: out_valid=%b cnt=%0d, required 0 and 0", out_valid, word_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fresh = $urandom();
        @(negedge clk);
        in_valid = 1'b1; in_data = fresh; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
            #1;
            if (out_valid) begin
                seen = 1;
                tests_run++;
                if (out_data !== fresh || out_check !== ref_chk(fresh)) begin
                    tests_failed++;
                    $display("FAIL rst_first_word: data=%h chk=%h, required %h %h",
                             out_data, out_check, fresh, ref_chk(fresh));
                end
            end
            @(negedge clk);
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL rst_timeout: no output after reset, required word %h", fresh);
        end
        tests_run++;
        if (word_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL rst_count: cnt=%0d, required 1", word_cnt);
        end
    endtask

`ifdef ECC_ERR_INJECT_EN
    task automatic test_inject();
        logic [5:0]  pos[3];
        logic [31:0] ed[3];
        logic [7:0]  ec[3];
        logic        ej[3];
        pos = '{6'd5, 6'd39, 6'd0};
        ed  = '{32'h0000_0020, 32'h0000_0000, 32'h0000_0000};
        ec  = '{8'h00, 8'h80, 8'h00};
        ej  = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inj_arm = ej[k]; inj_pos = pos[k]; in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            inj_arm = 1'b0; in_valid = 1'b1; in_data = 32'h0;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== ed[k] || out_check !== ec[k] || inj_done !== ej[k]) begin
                tests_failed++;
                $display("FAIL inj%0d: valid=%b data=%h chk=%h done=%b, required 1 %h %h %b",
                         k, out_valid, out_data, out_check, inj_done, ed[k], ec[k], ej[k]);
            end
            @(negedge clk);
            tests_run++;
            if (inj_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL inj%0d_pulse: done=%b, required 0", k, inj_done);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_sweep();
        test_backpressure();
        test_counter();
        test_reset_midstream();
`ifdef ECC_ERR_INJECT_EN
        test_inject();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
